// File: rtl/fib_gen_pkg.sv
// Shared types and constants for the Fibonacci term generator and its bench.
package fib_gen_pkg;

  typedef enum logic [1:0] {IDLE, EMIT, ADVANCE, DONE} state_t;

  localparam int          FIB_MAX_IDX_32 = 47;
  localparam logic [31:0] FIB_MAX_VAL_32 = 32'd2971215073;

endpackage

// File: rtl/fib_step.sv
// Combinational Fibonacci step: WIDTH-bit a+b with the carry-out reported separately.
module fib_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/fib_sequence_generator.sv
// Emits F(0), F(1), ... on a valid/ready stream until a requested count or WIDTH overflow.
// Optional macro FIB_INDEX_EN adds index_o, the index n of the term on term_o.
module fib_sequence_generator
  import fib_gen_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go_i,
  input  logic [CNT_W-1:0] num_terms_i,
  output logic [WIDTH-1:0] term_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             last_o,
  output logic             done_o,
  output logic             overflow_o
`ifdef FIB_INDEX_EN
  ,
  output logic [CNT_W-1:0] index_o
`endif
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a, b, sum;
  logic             carry;
  logic [CNT_W-1:0] cnt, req;
  logic             ovf_pending;
  logic             overflow;
  logic             count_hit;

  fib_step #(.WIDTH(WIDTH)) u_step (
    .a    (a),
    .b    (b),
    .sum  (sum),
    .carry(carry)
  );

  // ovf_pending means b is no longer representable, so a is the final term.
  assign count_hit  = (req != '0) && (cnt == req - 1'b1);
  assign term_o     = a;
  assign valid_o    = (state == EMIT);
  assign last_o     = (state == EMIT) && (count_hit || ovf_pending);
  assign done_o     = (state == DONE);
  assign overflow_o = overflow;
`ifdef FIB_INDEX_EN
  assign index_o    = cnt;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Dropping go_i outside IDLE always aborts, even over a same-cycle handshake.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (go_i) state_nxt = EMIT;
      EMIT: begin
        if (!go_i)        state_nxt = IDLE;
        else if (ready_i) state_nxt = last_o ? DONE : ADVANCE;
      end
      ADVANCE: state_nxt = go_i ? EMIT : IDLE;
      DONE:    if (!go_i) state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a           <= '0;
      b           <= {{(WIDTH-1){1'b0}}, 1'b1};
      cnt         <= '0;
      req         <= '0;
      ovf_pending <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          overflow <= 1'b0;
          if (go_i) begin
            req         <= num_terms_i;
            a           <= '0;
            b           <= {{(WIDTH-1){1'b0}}, 1'b1};
            cnt         <= '0;
            ovf_pending <= 1'b0;
          end
        end
        EMIT: begin
          // A count-terminated run reports no overflow even if both coincide.
          if (go_i && ready_i && last_o) overflow <= !count_hit;
        end
        ADVANCE: begin
          if (go_i) begin
            a           <= b;
            b           <= sum;
            ovf_pending <= ovf_pending | carry;
            if (cnt != '1) cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (!go_i) overflow <= 1'b0;
        end
      endcase
    end
  end

endmodule
